// File: rtl/damped_bus_arbiter.sv
// Round-robin arbiter for a shared damped net: one owner at a time, with idle
// turnaround cycles between owners and optional preemption of long holders.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no owner, all enables low; arbitrate among pending requests
// S_GRANT | one requester owns the net, its gnt/oe high; hold counter runs
// S_TURN  | enables low for TURNAROUND cycles so drivers never overlap
module damped_bus_arbiter #(
   parameter int N          = 4,
   parameter int TURNAROUND = 1,
   parameter int MAX_HOLD   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [N-1:0]         oe,
   output logic                 busy,
   output logic [$clog2(N)-1:0] owner,
   output logic                 preempt
);

   localparam int OW = $clog2(N);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_TURN  = 2'd2;

   localparam logic [7:0] HOLD_LIM  = (MAX_HOLD > 0) ? 8'(MAX_HOLD - 1) : 8'd0;
   localparam logic [3:0] TURN_LOAD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

   logic [1:0]    state_q;
   logic [N-1:0]  gnt_q;
   logic [OW-1:0] owner_q;
   logic [7:0]    hold_q;
   logic [3:0]    turn_q;
   logic          preempt_q;

   logic [OW-1:0] win;
   logic [OW-1:0] cand;
   logic          found;
   logic [N-1:0]  win_oh;
   logic          others_req;
   logic          hold_hit;
   logic          owner_drop;

   // Search starts just after the last owner so every requester gets a turn.
   always_comb begin
      win   = owner_q;
      cand  = '0;
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
         cand = OW'((int'(owner_q) + i) % N);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign win_oh     = N'(1) << win;
   assign others_req = |(req & ~gnt_q);
   assign hold_hit   = (MAX_HOLD != 0) && (hold_q >= HOLD_LIM);
   assign owner_drop = !req[owner_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         owner_q   <= OW'(N - 1);
         hold_q    <= '0;
         turn_q    <= '0;
         preempt_q <= 1'b0;
      end else begin
         preempt_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (|req) begin
                  gnt_q   <= win_oh;
                  owner_q <= win;
                  hold_q  <= '0;
                  state_q <= S_GRANT;
               end
            end
            S_GRANT: begin
               // A voluntary release wins over a preempt in the same cycle.
               if (owner_drop || (hold_hit && others_req)) begin
                  gnt_q     <= '0;
                  preempt_q <= !owner_drop;
                  if (TURNAROUND == 0) begin
                     state_q <= S_IDLE;
                  end else begin
                     state_q <= S_TURN;
                     turn_q  <= TURN_LOAD;
                  end
               end else if (hold_q != 8'hFF) begin
                  hold_q <= hold_q + 8'd1;
               end
            end
            S_TURN: begin
               if (turn_q == 4'd0) state_q <= S_IDLE;
               else                turn_q  <= turn_q - 4'd1;
            end
            default: begin
               state_q <= S_IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign oe      = gnt_q;
   assign busy    = (state_q != S_IDLE);
   assign owner   = owner_q;
   assign preempt = preempt_q;

endmodule

// File: tb/tb_damped_bus_arbiter.sv
// Scoreboard bench: two arbiter instances (turnaround 1 / hold 16, and
// turnaround 0 / hold 5) checked cycle by cycle against a behavioural model.
module tb_damped_bus_arbiter;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req_a, req_b;
   logic [3:0] gnt_a, oe_a, gnt_b, oe_b;
   logic       busy_a, busy_b, pre_a, pre_b;
   logic [1:0] own_a, own_b;

   always #5 clk = ~clk;

   damped_bus_arbiter #(.N(N), .TURNAROUND(1), .MAX_HOLD(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .oe(oe_a),
      .busy(busy_a), .owner(own_a), .preempt(pre_a));

   damped_bus_arbiter #(.N(N), .TURNAROUND(0), .MAX_HOLD(5)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .oe(oe_b),
      .busy(busy_b), .owner(own_b), .preempt(pre_b));

   typedef struct packed {
      logic [3:0] gnt;
      logic       busy;
      logic [1:0] owner;
      logic       preempt;
   } exp_t;

   exp_t q_a[$], q_b[$];
   exp_t ea, eb;
   int   checks = 0;
   int   errors = 0;

   // Model: an owner (if any) with the number of cycles it has held the net,
   // and a count of forced quiet cycles still to elapse before arbitration.
   int cfg_turn[2] = '{1, 0};
   int cfg_hold[2] = '{16, 5};
   int m_owner[2];
   int m_held[2];
   int m_quiet[2];
   bit m_owned[2];

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         m_owner[d] = N - 1;
         m_owned[d] = 1'b0;
         m_held[d]  = 0;
         m_quiet[d] = 0;
      end
   endfunction

   function automatic exp_t model_step(int d, logic [3:0] r);
      exp_t e;
      bit   pre = 1'b0;
      logic [3:0] others;
      others = r & ~(4'(1 << m_owner[d]));
      if (m_owned[d]) begin
         if (!r[m_owner[d]]) begin
            m_owned[d] = 1'b0;
            m_quiet[d] = cfg_turn[d];
         end else if (cfg_hold[d] != 0 && m_held[d] >= cfg_hold[d] && others != 0) begin
            m_owned[d] = 1'b0;
            m_quiet[d] = cfg_turn[d];
            pre = 1'b1;
         end else if (m_held[d] < 100000) begin
            m_held[d]++;
         end
      end else if (m_quiet[d] > 0) begin
         m_quiet[d]--;
      end else if (r != 0) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_owner[d] + k) % N;
            if (r[c]) begin
               m_owner[d] = c;
               break;
            end
         end
         m_owned[d] = 1'b1;
         m_held[d]  = 1;
      end
      e.gnt     = m_owned[d] ? 4'(1 << m_owner[d]) : 4'b0;
      e.busy    = m_owned[d] || (m_quiet[d] > 0);
      e.owner   = 2'(m_owner[d]);
      e.preempt = pre;
      return e;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic [3:0] a, logic [3:0] b);
      @(negedge clk);
      req_a = a;
      req_b = b;
      q_a.push_back(model_step(0, a));
      q_b.push_back(model_step(1, b));
   endtask

   task automatic check_reset_outputs();
      chk("rst_gnt_a", gnt_a, 0);  chk("rst_oe_a", oe_a, 0);
      chk("rst_busy_a", busy_a, 0); chk("rst_pre_a", pre_a, 0);
      chk("rst_owner_a", own_a, 3);
      chk("rst_gnt_b", gnt_b, 0);  chk("rst_owner_b", own_b, 3);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_a = '0;
      req_b = '0;
      q_a.delete();
      q_b.delete();
      repeat (2) @(posedge clk);
      #3;
      model_reset();
      rst_n = 1'b1;
      #1;
      check_reset_outputs();
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
         ea = q_a.pop_front();
         chk("a_gnt", gnt_a, ea.gnt);
         chk("a_oe", oe_a, ea.gnt);
         chk("a_busy", busy_a, ea.busy);
         chk("a_owner", own_a, ea.owner);
         chk("a_preempt", pre_a, ea.preempt);
         chk("a_onehot", $countones(oe_a) <= 1, 1);
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (q_b.size() > 0) begin
         eb = q_b.pop_front();
         chk("b_gnt", gnt_b, eb.gnt);
         chk("b_oe", oe_b, eb.gnt);
         chk("b_busy", busy_b, eb.busy);
         chk("b_owner", own_b, eb.owner);
         chk("b_preempt", pre_b, eb.preempt);
         chk("b_onehot", $countones(oe_b) <= 1, 1);
      end
   end

   // Observes dut_a grants directly to confirm round-robin order and gaps.
   bit         rr_log = 1'b0;
   int         rr_own[$];
   int         rr_gap[$];
   int         idle_run = 0;
   logic [3:0] prev_g = '0;

   initial forever begin
      @(posedge clk);
      #2;
      if (rr_log) begin
         if (gnt_a != 0 && prev_g == 0) begin
            for (int k = 0; k < N; k++) if (gnt_a[k]) rr_own.push_back(k);
            rr_gap.push_back(idle_run);
         end
         if (gnt_a == 0) idle_run++;
         else            idle_run = 0;
         prev_g = gnt_a;
      end
   end

   logic [3:0] r;
   logic [3:0] rb;

   initial begin
      req_a = '0;
      req_b = '0;
      do_reset();

      // Single requester: grant next cycle, release, turnaround.
      for (int c = 0; c < 6; c++) drive(4'b0001, 4'b0000);
      for (int c = 0; c < 4; c++) drive(4'b0000, 4'b0000);

      // All request; each owner lets go after three cycles of ownership.
      do_reset();
      rr_log = 1'b1;
      for (int c = 0; c < 40; c++) begin
         r = 4'hF;
         if (m_owned[0] && m_held[0] >= 3) r[m_owner[0]] = 1'b0;
         drive(r, 4'b0000);
      end
      rr_log = 1'b0;
      if (rr_own.size() < 5) chk("rr_grant_count", rr_own.size(), 5);
      for (int k = 0; k < 5 && k < rr_own.size(); k++) begin
         chk("rr_order", rr_own[k], k % N);
         if (k > 0) chk("rr_gap", rr_gap[k], 2);
      end

      // Preemption of a requester that never lets go.
      do_reset();
      for (int c = 0; c < 5; c++) drive(4'b0001, 4'b0010);
      for (int c = 0; c < 40; c++) drive(4'b0101, 4'b0110);
      drive(4'b0000, 4'b0000);
      drive(4'b0000, 4'b0000);

      // Lone owner far past the hold limit, then a competitor appears after
      // the hold count would have wrapped.
      do_reset();
      for (int c = 0; c < 261; c++) drive(4'b0001, 4'b0000);
      for (int c = 0; c < 10; c++) drive(4'b0101, 4'b0000);
      for (int c = 0; c < 4; c++) drive(4'b0000, 4'b0000);

      // Reset between edges while a grant is live.
      do_reset();
      for (int c = 0; c < 3; c++) drive(4'b0010, 4'b0000);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_oe_a", oe_a, 0);
      chk("async_busy_a", busy_a, 0);
      q_a.delete();
      q_b.delete();
      repeat (2) @(posedge clk);
      #3;
      model_reset();
      rst_n = 1'b1;
      #1;
      check_reset_outputs();
      for (int c = 0; c < 5; c++) drive(4'b1000, 4'b1000);
      for (int c = 0; c < 3; c++) drive(4'b0000, 4'b0000);

      // Zero turnaround with two alternating requesters.
      do_reset();
      for (int c = 0; c < 30; c++) drive(4'b0000, ((c / 3) % 2 == 0) ? 4'b0010 : 4'b0100);

      // Random persistent requests on both instances.
      do_reset();
      r  = '0;
      rb = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 5) == 0) r[k]  = ~r[k];
            if ($urandom_range(0, 4) == 0) rb[k] = ~rb[k];
         end
         drive(r, rb);
      end
      drive(4'b0000, 4'b0000);
      repeat (2) @(posedge clk);
      #3;
      chk("queue_drain", q_a.size() + q_b.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
